div5_digit_serializer: RTL and testbench

Sequential base-5 digit extractor downstream of the constant divide-by-5 core. Accepts a 16-bit unsigned operand over a valid/ready handshake. Iterates X <- floor(X/5) using one instance of the combinational div_16_5 core (X 16 bits in, Q 14 bits out). Streams the remainders out as base-5 digits, least-significant digit first, with a last flag.

---
 rtl/div5_digit_serializer_if.sv | 32 +++
 rtl/div5_digit_serializer.sv | 129 ++++++++++++
 tb/tb_div5_digit_serializer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div5_digit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : div5_digit_serializer_if
// Description : Operand-in / digit-out handshake bundle for the base-5
//               digit serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface div5_digit_serializer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic             dig_valid;
    logic             dig_ready;
    logic [2:0]       dig_out;
    logic             dig_last;
    logic [2:0]       dig_idx;
    logic             busy;

    // master: operand producer and digit consumer; slave: the serializer
    modport master (
        output in_valid, in_x, dig_ready,
        input  in_ready, dig_valid, dig_out, dig_last, dig_idx, busy
    );

    modport slave (
        input  in_valid, in_x, dig_ready,
        output in_ready, dig_valid, dig_out, dig_last, dig_idx, busy
    );
endinterface
`default_nettype wire

// File: rtl/div5_digit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : div5_digit_serializer (+ div_16_5 core)
// Description : Streams a 16-bit operand out as base-5 digits, LSD first,
//               by repeated constant division by 5.
// Revision    : 1.0 - initial release
// ============================================================================

module div_16_5 (
    input  wire logic [15:0] i_x,
    output logic      [13:0] o_q
);
    // floor(x*52429 / 2^18) equals floor(x/5) for every 16-bit x
    localparam logic [31:0] c_MAGIC = 32'd52429;

    assign o_q = 14'(({16'd0, i_x} * c_MAGIC) >> 18);
endmodule

module div5_digit_serializer #(
    parameter int WIDTH      = 16,
    parameter int QW         = 14,
    parameter int MAX_DIGITS = 7
) (
    input  wire logic               clk,
    input  wire logic               rst,
    div5_digit_serializer_if.slave  bus
);
    localparam int                  c_IDX_W  = $clog2(MAX_DIGITS);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE = c_IDX_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_EMIT = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_q;
    logic [2:0]         r_r;
    logic [c_IDX_W-1:0] r_idx;

    logic [QW-1:0]      w_q;
    logic [WIDTH-1:0]   w_q5;
    logic [2:0]         w_rem;
    logic               w_last;

    div_16_5 u_div (
        .i_x (r_work),
        .o_q (w_q)
    );

    assign w_q5   = (WIDTH'(w_q) << 2) + WIDTH'(w_q);
    assign w_rem  = 3'(r_work - w_q5);
    assign w_last = (r_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.in_valid)  w_state_nxt = c_CALC;
            c_CALC:                     w_state_nxt = c_EMIT;
            c_EMIT:  if (bus.dig_ready) w_state_nxt = w_last ? c_IDLE : c_CALC;
            default:                    w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs depend only on state and registers, never on in_valid/dig_ready
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.dig_valid = 1'b0;
        bus.dig_out   = 3'd0;
        bus.dig_last  = 1'b0;
        bus.dig_idx   = 3'd0;
        bus.busy      = 1'b0;
        case (r_state)
            c_IDLE: bus.in_ready = 1'b1;
            c_CALC: bus.busy     = 1'b1;
            c_EMIT: begin
                bus.busy      = 1'b1;
                bus.dig_valid = 1'b1;
                bus.dig_out   = r_r;
                bus.dig_last  = w_last;
                bus.dig_idx   = 3'(r_idx);
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_work <= bus.in_x;
                        r_idx  <= '0;
                    end
                end
                c_CALC: begin
                    r_q <= WIDTH'(w_q);
                    r_r <= w_rem;
                end
                c_EMIT: begin
                    if (bus.dig_ready) begin
                        if (w_last) begin
                            r_idx <= '0;
                        end else begin
                            r_work <= r_q;
                            r_idx  <= r_idx + c_IDX_ONE;
                        end
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_div5_digit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div5_digit_serializer
// Description : Directed self-checking bench with a digit scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div5_digit_serializer;
    typedef struct packed {
        logic [2:0] d;
        logic [2:0] idx;
        logic       last;
    } dig_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   hs_cnt;
    dig_t sb[$];

    div5_digit_serializer_if #(.WIDTH(16)) bus ();

    div5_digit_serializer #(
        .WIDTH      (16),
        .QW         (14),
        .MAX_DIGITS (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_model(input int x);
        dig_t e;
        int   v;
        int   i;
        v = x;
        i = 0;
        do begin
            e.d    = 3'(v % 5);
            e.idx  = 3'(i);
            v      = v / 5;
            e.last = (v == 0);
            sb.push_back(e);
            i++;
        end while (v != 0);
    endtask

    // Scores any handshake about to happen, then advances one clock edge
    task automatic step();
        dig_t e;
        logic hold;
        logic [6:0] held;
        hold = 1'b0;
        held = '0;
        if (!rst && bus.dig_valid === 1'b1) chk("dig_range", 32'(bus.dig_out < 3'd5), 1);
        if (!rst && bus.dig_valid === 1'b1 && bus.dig_ready) begin
            hs_cnt++;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL extra_digit observed=%0d expected=none", bus.dig_out);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("dig_out",  32'(bus.dig_out),  32'(e.d));
                chk("dig_idx",  32'(bus.dig_idx),  32'(e.idx));
                chk("dig_last", 32'(bus.dig_last), 32'(e.last));
            end
        end
        if (!rst && bus.dig_valid === 1'b1 && !bus.dig_ready) begin
            hold = 1'b1;
            held = {bus.dig_out, bus.dig_idx, bus.dig_last};
        end
        @(posedge clk);
        #1;
        if (hold && !rst)
            chk("hold_stable", 32'({bus.dig_valid, bus.dig_out, bus.dig_idx, bus.dig_last}),
                32'({1'b1, held}));
    endtask

    task automatic send(input int x);
        int n;
        bus.in_x     = 16'(x);
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        assert (n < 50) else begin
            failures++;
            $error("FAIL in_ready_timeout observed=%0d expected=<50", n);
        end
        push_model(x);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            step();
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        int hs0;
        int n;
        checks       = 0;
        failures     = 0;
        hs_cnt       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.dig_ready = 1'b1;

        // Reset for two cycles
        step();
        step();
        chk("rst_in_ready",  32'(bus.in_ready),  1);
        chk("rst_dig_valid", 32'(bus.dig_valid), 0);
        chk("rst_busy",      32'(bus.busy),      0);
        chk("rst_dig_out",   32'(bus.dig_out),   0);
        chk("rst_dig_idx",   32'(bus.dig_idx),   0);
        chk("rst_dig_last",  32'(bus.dig_last),  0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_no_digit", 32'(bus.dig_valid), 0);
        end

        // 23 -> 3,4 with latency checks
        send(23);
        chk("acc_busy",     32'(bus.busy),      1);
        chk("acc_in_ready", 32'(bus.in_ready),  0);
        chk("calc_novalid", 32'(bus.dig_valid), 0);
        step();
        chk("first_valid",  32'(bus.dig_valid), 1);
        drain();
        chk("23_in_ready",  32'(bus.in_ready),  1);
        chk("23_busy",      32'(bus.busy),      0);

        // Full scale
        send(65535);
        drain();
        chk("ffff_in_ready", 32'(bus.in_ready), 1);

        // 0 then 1 back-to-back, upstream holding in_valid
        send(0);
        bus.in_x     = 16'd1;
        bus.in_valid = 1'b1;
        step();
        chk("b2b_emit_ready", 32'(bus.in_ready),  0);
        chk("b2b_emit_valid", 32'(bus.dig_valid), 1);
        step();
        chk("b2b_idle_ready", 32'(bus.in_ready),  1);
        chk("b2b_idle_valid", 32'(bus.dig_valid), 0);
        push_model(1);
        step();
        bus.in_valid = 1'b0;
        chk("b2b_accept_busy", 32'(bus.busy), 1);
        drain();
        chk("b2b_in_ready", 32'(bus.in_ready), 1);

        // Backpressure on 124 with in_valid pulses while busy
        bus.dig_ready = 1'b0;
        send(124);
        hs0 = hs_cnt;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (bus.dig_valid !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            checks++;
            assert (n < 20) else begin
                failures++;
                $error("FAIL bp_valid_timeout observed=%0d expected=<20", n);
            end
            for (int j = 0; j < 4; j++) begin
                bus.in_valid = j[0];
                bus.in_x     = 16'd999;
                step();
            end
            bus.in_valid  = 1'b0;
            bus.dig_ready = 1'b1;
            step();
            bus.dig_ready = 1'b0;
        end
        bus.dig_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("bp_handshakes", 32'(hs_cnt - hs0), 3);
        chk("bp_sb_empty",   32'(sb.size()),    0);
        chk("bp_in_ready",   32'(bus.in_ready), 1);

        // Reset after the third digit handshake
        send(65535);
        hs0 = hs_cnt;
        n = 0;
        while (hs_cnt - hs0 < 3 && n < 50) begin
            step();
            n++;
        end
        checks++;
        assert (n < 50) else begin
            failures++;
            $error("FAIL mid_hs_timeout observed=%0d expected=<50", n);
        end
        rst = 1'b1;
        step();
        chk("mid_rst_valid",    32'(bus.dig_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready),  1);
        chk("mid_rst_busy",     32'(bus.busy),      0);
        rst = 1'b0;
        sb.delete();
        send(7);
        drain();
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
